pbp_ghr_ctrl: RTL and testbench
===============================

Name: pbp_ghr_ctrl

Overview:
- Global-history manager for the perceptron branch predictor.
- Holds the speculative GHR, which supplies the history used for each prediction, and the committed GHR, which is updated at resolution.
- Keeps an in-order checkpoint queue of in-flight predicted branches; restores history on mispredict or flush.
- Emits one registered training record per resolved branch to the predictor's update port.

Parameters:
GHR_LENGTH, 10, history bits; bit 0 = newest outcome
NR_CKPT, 8, checkpoint queue depth (power of two, >=2)
TAG_W, $clog2(NR_CKPT), checkpoint tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
flush_i  in  1  frontend flush; drops all in-flight checkpoints
debug_mode_i  in  1  while high: no allocation, resolutions ignored
pred_valid_i  in  1  decode issues a conditional-branch prediction
pred_pc_i  in  riscv::VLEN  PC of predicted branch
pred_taken_i  in  1  predicted direction
pred_ready_o  out  1  checkpoint can be allocated this cycle
pred_tag_o  out  TAG_W  slot allocated to the accepted prediction
spec_history_o  out  GHR_LENGTH  speculative GHR (history for the current prediction)
commit_history_o  out  GHR_LENGTH  committed GHR
resolve_valid_i  in  1  oldest in-flight branch resolved
resolve_tag_i  in  TAG_W  tag of resolving branch
resolve_taken_i  in  1  actual direction
resolve_mispredict_i  in  1  actual != predicted
upd_valid_o  out  1  training record valid (1-cycle pulse)
upd_pc_o  out  riscv::VLEN  PC of trained branch
upd_history_o  out  GHR_LENGTH  history captured when that branch was predicted
upd_taken_o  out  1  actual direction
upd_mispredict_o  out  1  mispredict flag
count_o  out  TAG_W+1  occupied checkpoints

Behaviour:
- Shift rule: new = {h[GHR_LENGTH-2:0], bit}.
- Reset (rst_i sampled high at clk edge):
  - spec GHR, commit GHR = 0.
  - Queue empty: head = tail = 0, count_o = 0.
  - upd_* = 0.
  - Reset overrides every other input, including mid-operation.
- pred_ready_o is combinational: = (count_o < NR_CKPT) && !debug_mode_i && !flush_i && !(resolve_valid_i && resolve_mispredict_i).
- Accept = pred_valid_i && pred_ready_o. On accept:
  - Slot[tail] <= {pred_pc_i, spec GHR, pred_taken_i}.
  - pred_tag_o = tail (combinational).
  - tail++ (wraps mod NR_CKPT).
  - spec GHR <= shift(spec GHR, pred_taken_i).
- spec_history_o shows the pre-shift value in the accept cycle.
- Resolution is in program order:
  - Accepted only if resolve_valid_i && count_o != 0 && resolve_tag_i == head && !debug_mode_i.
  - Otherwise it is ignored: no state change, upd_valid_o = 0 next cycle.
- Resolution, correct prediction:
  - commit GHR <= shift(commit, resolve_taken_i).
  - Pop head.
- Resolution, mispredict:
  - commit GHR <= shift(commit, resolve_taken_i).
  - spec GHR <= the same new value.
  - Queue emptied: head = tail = head+1, count = 0.
  - The same-cycle prediction is refused (ready low).
- Training output:
  - Every accepted resolution drives upd_* on the next cycle for exactly one cycle.
  - upd_history_o and upd_pc_o come from the popped slot; taken and mispredict come from the resolve inputs.
- Simultaneous accept + correct resolution: push and pop both happen; count unchanged; spec shifts with the prediction.
- Full: count = NR_CKPT → pred_ready_o = 0. There is no same-cycle bypass from a pop.
- flush_i without mispredict:
  - Queue emptied; spec GHR <= commit GHR.
  - A resolution in the same cycle is still processed first; spec then equals the new commit GHR.
- flush_i with mispredict in the same cycle: mispredict result.
- count_o = number of valid slots. Head and tail wrap modulo NR_CKPT.

Test Plan:
1. Reset, then predict T,T,N with tags 0,1,2 → spec_history_o before each accept = 0x000, 0x001, 0x003; final spec = 0x006; count_o = 3.
2. From (1), resolve tag0 taken, correct → next cycle: upd_valid_o = 1, upd_history_o = 0x000, upd_taken_o = 1. commit = 0x001; count_o = 2.
3. From (2), resolve tag1, actual N, mispredict, while pred_valid_i = 1 → pred_ready_o = 0; commit = spec = 0x002; count_o = 0; upd_mispredict_o = 1, upd_history_o = 0x001. The tag-2 entry is never trained.
4. Issue 8 predictions with no resolution → count_o = 8, pred_ready_o = 0. A 9th prediction plus a resolve of tag0 in the same cycle → pop only, count_o = 7. The next prediction gets tag 0 (wrap).
5. Resolve with resolve_tag_i != head, or while the queue is empty → no upd_valid_o, GHRs unchanged. debug_mode_i = 1 → pred_ready_o = 0 and resolutions ignored.
6. spec = 0x006, commit = 0x001, flush_i pulse → spec = 0x001, count_o = 0. Assert rst_i mid-stream → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pbp_ghr_ctrl.sv
// ---------------------------------------------------------------------------
// PbpGhrCtrl : global-history manager for the perceptron branch predictor.
//
// Keeps two global history registers:
//   - speculative GHR: shifted by every accepted prediction; it supplies the
//     history used by the prediction currently being made
//   - committed GHR  : shifted by every accepted (in-order) resolution
// In-flight predicted branches sit in an in-order checkpoint queue holding
// their PC and the history they were predicted with. A mispredict or a
// frontend flush empties the queue and rewinds the speculative GHR. Each
// accepted resolution produces one registered training record.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               frontend flush, drops all in-flight checkpoints
//   debug_mode_i          blocks allocation and ignores resolutions
//   pred_valid_i/pc/taken prediction issued by decode
//   pred_ready_o          a checkpoint can be allocated this cycle
//   pred_tag_o            slot handed to the accepted prediction
//   spec_history_o        speculative GHR (pre-shift in the accept cycle)
//   commit_history_o      committed GHR
//   resolve_*_i           resolution of the oldest in-flight branch
//   upd_*_o               one-cycle training record for the predictor
//   count_o               number of occupied checkpoints
// ---------------------------------------------------------------------------
module pbp_ghr_ctrl #(
  parameter int GHR_LENGTH = 10,
  parameter int NR_CKPT    = 8,
  parameter int TAG_W      = $clog2(NR_CKPT),
  parameter int VLEN       = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  input  logic                  pred_valid_i,
  input  logic [VLEN-1:0]       pred_pc_i,
  input  logic                  pred_taken_i,
  output logic                  pred_ready_o,
  output logic [TAG_W-1:0]      pred_tag_o,
  output logic [GHR_LENGTH-1:0] spec_history_o,
  output logic [GHR_LENGTH-1:0] commit_history_o,
  input  logic                  resolve_valid_i,
  input  logic [TAG_W-1:0]      resolve_tag_i,
  input  logic                  resolve_taken_i,
  input  logic                  resolve_mispredict_i,
  output logic                  upd_valid_o,
  output logic [VLEN-1:0]       upd_pc_o,
  output logic [GHR_LENGTH-1:0] upd_history_o,
  output logic                  upd_taken_o,
  output logic                  upd_mispredict_o,
  output logic [TAG_W:0]        count_o
);

  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(NR_CKPT);
  localparam logic [TAG_W-1:0] TAG_ONE    = (TAG_W)'(1);

  logic [GHR_LENGTH-1:0] r_specGhr;
  logic [GHR_LENGTH-1:0] r_commitGhr;
  logic [TAG_W-1:0]      r_head;
  logic [TAG_W-1:0]      r_tail;
  logic [TAG_W:0]        r_count;

  // The predicted direction is not stored: training uses the actual
  // direction and mispredict flag supplied with the resolution.
  logic [VLEN-1:0]       r_slotPc   [NR_CKPT];
  logic [GHR_LENGTH-1:0] r_slotHist [NR_CKPT];

  logic                  r_updValid;
  logic [VLEN-1:0]       r_updPc;
  logic [GHR_LENGTH-1:0] r_updHist;
  logic                  r_updTaken;
  logic                  r_updMispredict;

  logic                  w_accept;
  logic                  w_resAccept;
  logic                  w_mispredict;
  logic [GHR_LENGTH-1:0] w_commitNext;
  logic [GHR_LENGTH-1:0] w_specShift;

  // Handshake and resolution qualification. Ready deliberately looks at the
  // raw mispredict request (not the qualified one) so a restore cycle never
  // races with a new allocation.
  always_comb begin
    pred_ready_o = (r_count < FULL_COUNT) && !debug_mode_i && !flush_i &&
                   !(resolve_valid_i && resolve_mispredict_i);
    w_accept     = pred_valid_i && pred_ready_o;
    w_resAccept  = resolve_valid_i && (r_count != '0) &&
                   (resolve_tag_i == r_head) && !debug_mode_i;
    w_mispredict = w_resAccept && resolve_mispredict_i;
    w_commitNext = {r_commitGhr[GHR_LENGTH-2:0], resolve_taken_i};
    w_specShift  = {r_specGhr[GHR_LENGTH-2:0], pred_taken_i};
  end

  assign pred_tag_o       = r_tail;
  assign spec_history_o   = r_specGhr;
  assign commit_history_o = r_commitGhr;
  assign count_o          = r_count;
  assign upd_valid_o      = r_updValid;
  assign upd_pc_o         = r_updPc;
  assign upd_history_o    = r_updHist;
  assign upd_taken_o      = r_updTaken;
  assign upd_mispredict_o = r_updMispredict;

  // Checkpoint payload storage; contents are only meaningful while counted
  // as occupied, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_accept) begin
      r_slotPc[r_tail]   <= pred_pc_i;
      r_slotHist[r_tail] <= r_specGhr;
    end
  end

  // History registers and queue pointers. A mispredict outranks a flush;
  // a flush still lets a same-cycle correct resolution commit first, which
  // is why the spec GHR is reloaded from the post-resolution commit value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_specGhr   <= '0;
      r_commitGhr <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      if (w_resAccept) begin
        r_commitGhr <= w_commitNext;
      end
      if (w_mispredict) begin
        r_specGhr <= w_commitNext;
        r_head    <= r_head + TAG_ONE;
        r_tail    <= r_head + TAG_ONE;
        r_count   <= '0;
      end else if (flush_i) begin
        r_specGhr <= w_resAccept ? w_commitNext : r_commitGhr;
        r_head    <= r_tail;
        r_count   <= '0;
      end else begin
        if (w_accept) begin
          r_specGhr <= w_specShift;
          r_tail    <= r_tail + TAG_ONE;
        end
        if (w_resAccept) begin
          r_head <= r_head + TAG_ONE;
        end
        case ({w_accept, w_resAccept})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Training record: a one-cycle pulse per accepted resolution, payload
  // zeroed otherwise so the update port is quiet between records.
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_resAccept) begin
      r_updValid      <= 1'b0;
      r_updPc         <= '0;
      r_updHist       <= '0;
      r_updTaken      <= 1'b0;
      r_updMispredict <= 1'b0;
    end else begin
      r_updValid      <= 1'b1;
      r_updPc         <= r_slotPc[r_head];
      r_updHist       <= r_slotHist[r_head];
      r_updTaken      <= resolve_taken_i;
      r_updMispredict <= resolve_mispredict_i;
    end
  end

endmodule

// File: tb/tb_pbp_ghr_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pbp_ghr_ctrl: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pbp_ghr_ctrl;

  localparam int GHR_LENGTH = 10;
  localparam int NR_CKPT    = 8;
  localparam int TAG_W      = 3;
  localparam int VLEN       = 64;
  localparam int GHR_MASK   = (1 << GHR_LENGTH) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  debugMode;
  logic                  predValid;
  logic [VLEN-1:0]       predPc;
  logic                  predTaken;
  logic                  predReady;
  logic [TAG_W-1:0]      predTag;
  logic [GHR_LENGTH-1:0] specHistory;
  logic [GHR_LENGTH-1:0] commitHistory;
  logic                  resolveValid;
  logic [TAG_W-1:0]      resolveTag;
  logic                  resolveTaken;
  logic                  resolveMispredict;
  logic                  updValid;
  logic [VLEN-1:0]       updPc;
  logic [GHR_LENGTH-1:0] updHistory;
  logic                  updTaken;
  logic                  updMispredict;
  logic [TAG_W:0]        count;

  pbp_ghr_ctrl #(
    .GHR_LENGTH(GHR_LENGTH), .NR_CKPT(NR_CKPT), .TAG_W(TAG_W), .VLEN(VLEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(debugMode),
    .pred_valid_i(predValid), .pred_pc_i(predPc), .pred_taken_i(predTaken),
    .pred_ready_o(predReady), .pred_tag_o(predTag),
    .spec_history_o(specHistory), .commit_history_o(commitHistory),
    .resolve_valid_i(resolveValid), .resolve_tag_i(resolveTag),
    .resolve_taken_i(resolveTaken), .resolve_mispredict_i(resolveMispredict),
    .upd_valid_o(updValid), .upd_pc_o(updPc), .upd_history_o(updHistory),
    .upd_taken_o(updTaken), .upd_mispredict_o(updMispredict), .count_o(count)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight branches in program order, each remembering
  // its tag, PC and the history seen when it was predicted.
  typedef struct {
    int          tag;
    logic [63:0] pc;
    int          hist;
  } entry_t;

  entry_t      mQueue[$];
  int          mSpec, mCommit, mNextTag;
  bit          eUpdValid, eUpdTaken, eUpdMis;
  logic [63:0] eUpdPc;
  int          eUpdHist;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int shiftIn(input int h, input bit b);
    return ((h * 2) + (b ? 1 : 0)) & GHR_MASK;
  endfunction

  task automatic applyStimulus(input bit pv, input logic [63:0] pc, input bit pt,
                               input bit rv, input int rtag, input bit rt,
                               input bit rm, input bit fl, input bit dbg);
    predValid         = pv;
    predPc            = pc;
    predTaken         = pt;
    resolveValid      = rv;
    resolveTag        = TAG_W'(rtag);
    resolveTaken      = rt;
    resolveMispredict = rm;
    flush             = fl;
    debugMode         = dbg;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 64'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic modelReset();
    mQueue.delete();
    mSpec = 0; mCommit = 0; mNextTag = 0;
    eUpdValid = 0; eUpdTaken = 0; eUpdMis = 0; eUpdPc = '0; eUpdHist = 0;
  endtask

  // One clock cycle with whatever inputs are currently applied: combinational
  // outputs are checked before the edge, the model advances, and the
  // registered training record is checked just after the edge.
  task automatic runCycle();
    bit resAcc, ready, acc, mis;
    int newCommit;
    entry_t e;
    #1;
    resAcc = resolveValid && (mQueue.size() != 0) && !debugMode &&
             (int'(resolveTag) == mQueue[0].tag);
    ready  = (mQueue.size() < NR_CKPT) && !debugMode && !flush &&
             !(resolveValid && resolveMispredict);
    acc    = predValid && ready;
    mis    = resAcc && resolveMispredict;
    checkOutput("pred_ready", 64'(predReady), 64'(ready));
    checkOutput("spec_hist", 64'(specHistory), 64'(mSpec));
    checkOutput("commit_hist", 64'(commitHistory), 64'(mCommit));
    checkOutput("count", 64'(count), 64'(mQueue.size()));
    if (acc) checkOutput("pred_tag", 64'(predTag), 64'(mNextTag));

    eUpdValid = resAcc;
    eUpdPc    = resAcc ? mQueue[0].pc : 64'h0;
    eUpdHist  = resAcc ? mQueue[0].hist : 0;
    eUpdTaken = resAcc && resolveTaken;
    eUpdMis   = resAcc && resolveMispredict;

    newCommit = resAcc ? shiftIn(mCommit, resolveTaken) : mCommit;
    if (mis) begin
      mSpec    = newCommit;
      mNextTag = (mQueue[0].tag + 1) % NR_CKPT;
      mQueue.delete();
    end else if (flush) begin
      mSpec = newCommit;
      mQueue.delete();
    end else begin
      if (resAcc) void'(mQueue.pop_front());
      if (acc) begin
        e.tag = mNextTag; e.pc = predPc; e.hist = mSpec;
        mQueue.push_back(e);
        mNextTag = (mNextTag + 1) % NR_CKPT;
        mSpec    = shiftIn(mSpec, predTaken);
      end
    end
    mCommit = newCommit;

    @(posedge clk);
    #1;
    checkOutput("upd_valid", 64'(updValid), 64'(eUpdValid));
    checkOutput("upd_pc", updPc, eUpdPc);
    checkOutput("upd_hist", 64'(updHistory), 64'(eUpdHist));
    checkOutput("upd_taken", 64'(updTaken), 64'(eUpdTaken));
    checkOutput("upd_mis", 64'(updMispredict), 64'(eUpdMis));
  endtask

  task automatic resetDut(input bit keepTraffic);
    rst = 1'b1;
    if (!keepTraffic) idleInputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
    modelReset();
    checkOutput("rst_spec", 64'(specHistory), 64'h0);
    checkOutput("rst_commit", 64'(commitHistory), 64'h0);
    checkOutput("rst_count", 64'(count), 64'h0);
    checkOutput("rst_upd_valid", 64'(updValid), 64'h0);
    checkOutput("rst_upd_hist", 64'(updHistory), 64'h0);
    checkOutput("rst_upd_pc", updPc, 64'h0);
    checkOutput("rst_upd_mis", 64'(updMispredict), 64'h0);
  endtask

  task automatic predict(input logic [63:0] pc, input bit taken);
    applyStimulus(1, pc, taken, 0, 0, 0, 0, 0, 0);
    runCycle();
  endtask

  initial begin
    int planSpec[3];
    bit planDir[3];
    int rtag;
    planSpec = '{0, 1, 3};
    planDir  = '{1, 1, 0};
    idleInputs();
    rst = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    resetDut(0);

    // Plan 1: T,T,N
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 64'h1000 + 64'(4 * i), planDir[i], 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("p1_spec_pre", 64'(specHistory), 64'(planSpec[i]));
      checkOutput("p1_tag", 64'(predTag), 64'(i));
      runCycle();
    end
    checkOutput("p1_spec", 64'(specHistory), 64'h006);
    checkOutput("p1_count", 64'(count), 64'd3);

    // Plan 2: resolve tag0 taken, correct
    applyStimulus(0, 64'h0, 0, 1, 0, 1, 0, 0, 0);
    runCycle();
    checkOutput("p2_upd_valid", 64'(updValid), 64'h1);
    checkOutput("p2_upd_hist", 64'(updHistory), 64'h000);
    checkOutput("p2_upd_taken", 64'(updTaken), 64'h1);
    checkOutput("p2_commit", 64'(commitHistory), 64'h001);
    checkOutput("p2_count", 64'(count), 64'd2);

    // Plan 3: mispredict on tag1 while a prediction is offered
    applyStimulus(1, 64'h2000, 1, 1, 1, 0, 1, 0, 0);
    #1;
    checkOutput("p3_ready", 64'(predReady), 64'h0);
    runCycle();
    checkOutput("p3_commit", 64'(commitHistory), 64'h002);
    checkOutput("p3_spec", 64'(specHistory), 64'h002);
    checkOutput("p3_count", 64'(count), 64'd0);
    checkOutput("p3_upd_mis", 64'(updMispredict), 64'h1);
    checkOutput("p3_upd_hist", 64'(updHistory), 64'h001);
    idleInputs();
    runCycle();

    // Plan 4: fill, then pop-only while full, then tag wrap
    resetDut(0);
    for (int i = 0; i < NR_CKPT; i++) predict(64'h3000 + 64'(4 * i), i[0]);
    checkOutput("p4_count_full", 64'(count), 64'd8);
    applyStimulus(1, 64'h4000, 1, 1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("p4_ready_full", 64'(predReady), 64'h0);
    runCycle();
    checkOutput("p4_count_pop", 64'(count), 64'd7);
    applyStimulus(1, 64'h4004, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("p4_wrap_tag", 64'(predTag), 64'h0);
    runCycle();

    // Plan 5: wrong-tag resolve, empty-queue resolve, debug mode
    applyStimulus(0, 64'h0, 0, 1, 3, 1, 1, 0, 0);
    runCycle();
    checkOutput("p5_wrongtag_upd", 64'(updValid), 64'h0);
    applyStimulus(1, 64'h5000, 1, 1, 1, 1, 0, 0, 1);
    #1;
    checkOutput("p5_dbg_ready", 64'(predReady), 64'h0);
    runCycle();
    checkOutput("p5_dbg_upd", 64'(updValid), 64'h0);
    resetDut(0);
    applyStimulus(0, 64'h0, 0, 1, 0, 1, 0, 0, 0);
    runCycle();
    checkOutput("p5_empty_upd", 64'(updValid), 64'h0);
    checkOutput("p5_empty_commit", 64'(commitHistory), 64'h0);

    // Plan 6: flush restores spec from commit, then mid-stream reset
    predict(64'h6000, 1);
    predict(64'h6004, 1);
    predict(64'h6008, 0);
    applyStimulus(0, 64'h0, 0, 1, 0, 1, 0, 0, 0);
    runCycle();
    checkOutput("p6_spec_pre", 64'(specHistory), 64'h006);
    checkOutput("p6_commit_pre", 64'(commitHistory), 64'h001);
    applyStimulus(0, 64'h0, 0, 0, 0, 0, 0, 1, 0);
    runCycle();
    checkOutput("p6_flush_spec", 64'(specHistory), 64'h001);
    checkOutput("p6_flush_count", 64'(count), 64'd0);
    predict(64'h7000, 1);
    predict(64'h7004, 0);
    applyStimulus(1, 64'h7008, 1, 1, mQueue[0].tag, 1, 0, 0, 0);
    resetDut(1);

    // Randomized traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetDut(0);
      end else begin
        if (mQueue.size() != 0 && $urandom_range(0, 9) < 8) rtag = mQueue[0].tag;
        else rtag = int'($urandom_range(0, NR_CKPT - 1));
        applyStimulus($urandom_range(0, 9) < 6, {$urandom, $urandom},
                      1'($urandom), $urandom_range(0, 9) < 4, rtag,
                      1'($urandom), $urandom_range(0, 9) < 2,
                      $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
        runCycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
